// File: rtl/sipo_deser_pkg.sv
// Shared types and sizing helpers for the sipo_deser serial-to-parallel deserialiser.
// Frame length depends on SIPO_DESER_PARITY_EN (adds one even-parity bit per frame).
package sipo_deser_pkg;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned count_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned frame_bits(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register with selectable bit order, frame bit counter and word-complete pulse.
module sipo_shift_core #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned FRAME_BITS = WIDTH,
    parameter int unsigned CW         = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             serial_in,
    output logic [WIDTH-1:0] shift_out,
    output logic [CW-1:0]    bit_count,
    output logic             word_done,
    output logic [WIDTH-1:0] done_word
);

    logic [WIDTH-1:0] shift_q, shift_d, shifted;
    logic [CW-1:0]    count_q, count_d;
    logic             data_bit, last_bit;

    if (MSB_FIRST) begin : gen_msb_first
        assign shifted = {shift_q[WIDTH-2:0], serial_in};
    end else begin : gen_lsb_first
        assign shifted = {serial_in, shift_q[WIDTH-1:1]};
    end

    // Bits past WIDTH in a frame (the parity bit) are counted but not shifted.
    assign data_bit = (count_q < CW'(WIDTH));
    assign last_bit = (count_q == CW'(FRAME_BITS - 1));

    always_comb begin
        shift_d   = shift_q;
        count_d   = count_q;
        word_done = 1'b0;
        if (bit_valid) begin
            if (data_bit) begin
                shift_d = shifted;
            end
            count_d   = last_bit ? '0 : count_q + CW'(1);
            word_done = last_bit;
        end
    end

    assign done_word = shift_d;
    assign shift_out = shift_q;
    assign bit_count = count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Deserialiser top: shift core plus one-entry valid/ready output register, overrun and parity.
// Optional even-parity framing enabled by defining SIPO_DESER_PARITY_EN.
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            bit_valid,
    input  logic                            serial_in,
    output logic [WIDTH-1:0]                shift_out,
    output logic [$clog2(WIDTH+1)-1:0]      bit_count,
    output logic [WIDTH-1:0]                word_out,
    output logic                            word_valid,
    input  logic                            word_ready,
    output logic                            overrun,
    output logic                            parity_err
);

    localparam int unsigned CW         = count_width(WIDTH);
    localparam int unsigned FRAME_BITS = frame_bits(WIDTH);

    out_state_e       state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d, done_word;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d, perr_new;
    logic             word_done;

    sipo_shift_core #(
        .WIDTH      (WIDTH),
        .MSB_FIRST  (MSB_FIRST),
        .FRAME_BITS (FRAME_BITS),
        .CW         (CW)
    ) u_core (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .serial_in  (serial_in),
        .shift_out  (shift_out),
        .bit_count  (bit_count),
        .word_done  (word_done),
        .done_word  (done_word)
    );

`ifdef SIPO_DESER_PARITY_EN
    // On word_done, serial_in is the parity bit itself.
    assign perr_new = (^done_word) ^ serial_in;
`else
    assign perr_new = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        unique case (state_q)
            OUT_EMPTY: begin
                if (word_done) begin
                    word_d  = done_word;
                    perr_d  = perr_new;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (word_ready) begin
                    if (word_done) begin
                        word_d = done_word;
                        perr_d = perr_new;
                    end else begin
                        state_d = OUT_EMPTY;
                    end
                end else if (word_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= OUT_EMPTY;
            word_q    <= '0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign word_out   = word_q;
    assign word_valid = (state_q == OUT_FULL);
    assign overrun    = overrun_q;
    assign parity_err = perr_q;

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserialiser, successor to the fixed 4-bit SIPO shift register. Shifts qualified serial bits into a WIDTH-bit register with selectable bit order, counts bits to frame words, and hands each completed word to a downstream consumer through a one-entry valid/ready output register. Sits between a serial link front-end and word-wide datapath logic.

Parameters:
WIDTH, 8, word width in bits; legal range >= 2
MSB_FIRST, 0, 0 = first received bit ends up in word bit 0 (new bit enters at MSB, register shifts right); 1 = first received bit ends up in word bit WIDTH-1 (new bit enters at LSB, register shifts left)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous active-low reset; sampled only on rising clk edge
bit_valid  input  1  serial_in is sampled this cycle when high
serial_in  input  1  serial data bit
shift_out  output  WIDTH  live shift-register contents
bit_count  output  $clog2(WIDTH+1)  bits received in the current frame
word_out  output  WIDTH  framed word; stable while word_valid is high
word_valid  output  1  word_out holds an unconsumed word
word_ready  input  1  consumer accepts word_out when high together with word_valid
overrun  output  1  sticky: a completed word was dropped
parity_err  output  1  parity result for word_out (see Optional Feature)

Behaviour:
- Reset (reset==0 at a clk edge): shift_out=0, bit_count=0, word_out=0, word_valid=0, overrun=0, parity_err=0, output FSM=OUT_EMPTY. Reset overrides all other inputs. Mid-frame reset discards partial bits; the next bit starts a new frame.
- bit_valid==0: shift register and bit_count hold. Gaps of any length between bits are legal.
- bit_valid==1: MSB_FIRST=0: shift_out <= {serial_in, shift_out[WIDTH-1:1]}. MSB_FIRST=1: shift_out <= {shift_out[WIDTH-2:0], serial_in}.
- bit_count increments on each accepted bit. On the last bit of a frame (bit_count==WIDTH-1 when the optional feature is off), bit_count wraps to 0 and a word-complete event fires. The completed word is the shifted value including that bit.
- Output FSM:
  - OUT_EMPTY: on word-complete, word_out <= completed word, word_valid <= 1, go to OUT_FULL.
  - OUT_FULL: if word_ready==1, the word is consumed this cycle.
    - Consumed, no word-complete: word_valid <= 0, go to OUT_EMPTY.
    - Consumed with simultaneous word-complete: load the new word, stay in OUT_FULL, word_valid stays 1, no overrun.
    - Not consumed with word-complete: the new word is dropped, word_out is unchanged, overrun <= 1.
- Latency: word_valid rises on the same clk edge that samples the final bit, so it is visible in the cycle after that bit was presented.
- overrun stays high until reset. The shift register and bit_count keep running regardless of backpressure.
- word_ready is ignored while word_valid==0.

Optional Feature:
- Macro: SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - bit_count runs 0..WIDTH and wraps on the parity bit.
  - The parity bit is not shifted into shift_out.
  - Word-complete fires on the parity bit.
  - parity_err is loaded together with word_out: 1 if XOR(data bits, parity bit) != 0.
  - Dropped words do not update parity_err.
- Undefined: frames are WIDTH bits and parity_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Package sipo_deser_pkg:
  - output FSM enum {OUT_EMPTY, OUT_FULL};
  - function for count width ($clog2(WIDTH+1));
  - FRAME_BITS constant, WIDTH or WIDTH+1 depending on the macro.
- Sub-module sipo_shift_core: shift register, bit order, bit counter and word-complete pulse.
- The top level holds the output register, FSM, overrun and parity check.

Test Plan:
- Reset: hold reset=0 for 3 cycles with bit_valid=1 -> every output is 0 and bit_count stays 0.
- WIDTH=4, MSB_FIRST=0, bits 1,0,1,1 with idle gaps -> word_out=4'b1101 and word_valid=1 the cycle after the 4th bit; word_ready=1 then clears word_valid.
- Bit order: WIDTH=4, MSB_FIRST=1, same bits -> word_out=4'b1011.
- Backpressure: WIDTH=4, word_ready=0, send 8 bits (0x3 then 0xC in arrival order) -> word_out keeps the first word, overrun=1; raising word_ready clears word_valid, and overrun stays 1.
- Back-to-back: word_ready pulsed high exactly on the edge where the next word completes -> new word loaded, word_valid never drops, overrun=0.
- Mid-frame reset, then parity:
  - 2 bits, reset for 1 cycle, then 1,1,1,1 -> word_out=4'hF.
  - With SIPO_DESER_PARITY_EN, data 1,1,1,0 plus parity 0 -> parity_err=1.
  - With SIPO_DESER_PARITY_EN, data 1,1,1,0 plus parity 1 -> parity_err=0.
